pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 194 +++++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Hazard/stall controller for a five-stage in-order pipeline. It resolves
//   load-use hazards by a one-cycle stall, squashes wrong-path instructions
//   on a taken branch/jump, freezes the pipe while the data memory is busy,
//   and latches a sticky fault if the memory never answers.
//
//   Optional feature macro: STALL_COUNTER_EN adds a saturating 16-bit
//   Stall_Count output that counts cycles with PC_Enable low (RUN/MEM_WAIT).
//
// Ports
//   Clk, Reset_n          clock, asynchronous active-low reset
//   MemRead_EX            load instruction in EX
//   Write_Register_EX     destination register of the EX instruction
//   Rs_ID, Rt_ID          source registers of the ID instruction
//   Branch_Taken_EX       resolved taken branch/jump in EX
//   Mem_Access_MEM        load or store in MEM
//   Mem_Ready             data memory completion strobe
//   *_Enable              stage register load enables
//   IF_ID_Flush/ID_EX_Flush  load a NOP into that stage register
//   MEM_WB_Bubble         clear write-back controls on the next MEM_WB load
//   Mem_Req               memory request
//   Mem_Timeout           sticky memory timeout fault
//   Stall_Count           (STALL_COUNTER_EN only) saturating stall counter
//
// Outputs are combinational from state and inputs; all outputs are forced to
// 0 while Reset_n is low.

`timescale 1ns/1ps

module pipeline_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT_CYCLES = 15
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       MemRead_EX,
  input  logic [4:0] Write_Register_EX,
  input  logic [4:0] Rs_ID,
  input  logic [4:0] Rt_ID,
  input  logic       Branch_Taken_EX,
  input  logic       Mem_Access_MEM,
  input  logic       Mem_Ready,
  output logic       PC_Enable,
  output logic       IF_ID_Enable,
  output logic       ID_EX_Enable,
  output logic       EX_MEM_Enable,
  output logic       MEM_WB_Enable,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Flush,
  output logic       MEM_WB_Bubble,
  output logic       Mem_Req,
  output logic       Mem_Timeout
`ifdef STALL_COUNTER_EN
  ,
  output logic [15:0] Stall_Count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

  // Last counter value that may still wait; reaching it without Mem_Ready faults.
  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT_CYCLES - 32'd1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic load_use_s;
  logic mem_busy_s;

  // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use_s = MemRead_EX & (Write_Register_EX != 5'd0) &
                      ((Write_Register_EX == Rs_ID) | (Write_Register_EX == Rt_ID));

  // Memory is outstanding and has not completed this cycle -> freeze the pipe.
  assign mem_busy_s = (((state_q == RUN) & Mem_Access_MEM) | (state_q == MEM_WAIT)) & ~Mem_Ready;

  // State and timeout counter registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (mem_busy_s) begin
          state_d = MEM_WAIT;
          cnt_d   = 8'd0;
        end else begin
          state_d = RUN;
          cnt_d   = cnt_q;
        end
      end
      MEM_WAIT: begin
        if (Mem_Ready) begin
          state_d = RUN;
          cnt_d   = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = FAULT;
          cnt_d   = cnt_q;
        end else begin
          state_d = MEM_WAIT;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      FAULT: begin
        state_d = FAULT;
        cnt_d   = cnt_q;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Output decode; the normal (non-frozen) decode gives branch priority over load-use.
  always_comb begin
    PC_Enable     = 1'b0;
    IF_ID_Enable  = 1'b0;
    ID_EX_Enable  = 1'b0;
    EX_MEM_Enable = 1'b0;
    MEM_WB_Enable = 1'b0;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    MEM_WB_Bubble = 1'b0;
    Mem_Req       = 1'b0;
    Mem_Timeout   = 1'b0;
    if (!Reset_n) begin
      Mem_Req = 1'b0;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          Mem_Req = (state_q == MEM_WAIT) | Mem_Access_MEM;
          if (mem_busy_s) begin
            MEM_WB_Enable = 1'b1;
            MEM_WB_Bubble = 1'b1;
          end else begin
            PC_Enable     = 1'b1;
            IF_ID_Enable  = 1'b1;
            ID_EX_Enable  = 1'b1;
            EX_MEM_Enable = 1'b1;
            MEM_WB_Enable = 1'b1;
            if (Branch_Taken_EX) begin
              IF_ID_Flush = 1'b1;
              ID_EX_Flush = 1'b1;
            end else if (load_use_s) begin
              PC_Enable    = 1'b0;
              IF_ID_Enable = 1'b0;
              ID_EX_Flush  = 1'b1;
            end else begin
              IF_ID_Flush = 1'b0;
            end
          end
        end
        FAULT: begin
          Mem_Timeout = 1'b1;
        end
        default: begin
          Mem_Timeout = 1'b0;
        end
      endcase
    end
  end

`ifdef STALL_COUNTER_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles the PC is held in RUN/MEM_WAIT.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_cnt_q <= 16'd0;
    end else if ((state_q != FAULT) && !PC_Enable && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign Stall_Count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
`timescale 1ns/1ps

module tb_pipeline_hazard_controller;

  localparam int T = 15;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       MemRead_EX = 1'b0;
  logic [4:0] Write_Register_EX = 5'd0;
  logic [4:0] Rs_ID = 5'd0;
  logic [4:0] Rt_ID = 5'd0;
  logic       Branch_Taken_EX = 1'b0;
  logic       Mem_Access_MEM = 1'b0;
  logic       Mem_Ready = 1'b0;
  logic       PC_Enable, IF_ID_Enable, ID_EX_Enable, EX_MEM_Enable, MEM_WB_Enable;
  logic       IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble, Mem_Req, Mem_Timeout;
`ifdef STALL_COUNTER_EN
  logic [15:0] Stall_Count;
`endif

  pipeline_hazard_controller #(.MEM_TIMEOUT_CYCLES(T)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .MemRead_EX(MemRead_EX), .Write_Register_EX(Write_Register_EX),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Branch_Taken_EX(Branch_Taken_EX),
    .Mem_Access_MEM(Mem_Access_MEM), .Mem_Ready(Mem_Ready),
    .PC_Enable(PC_Enable), .IF_ID_Enable(IF_ID_Enable), .ID_EX_Enable(ID_EX_Enable),
    .EX_MEM_Enable(EX_MEM_Enable), .MEM_WB_Enable(MEM_WB_Enable),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .MEM_WB_Bubble(MEM_WB_Bubble), .Mem_Req(Mem_Req), .Mem_Timeout(Mem_Timeout)
`ifdef STALL_COUNTER_EN
    , .Stall_Count(Stall_Count)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [9:0] o;
    int         sc;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: memory outstanding flag, completed wait cycles, fault flag.
  bit m_wait   = 1'b0;
  int m_waited = 0;
  bit m_fault  = 1'b0;
  int m_stall  = 0;

  // Apply one cycle of inputs and predict the outputs visible for that cycle.
  task automatic drive(input bit rst, input bit mr, input logic [4:0] wr,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input bit br, input bit ma, input bit rdy, input string tag);
    bit pc, ifid, idex, exmem, memwb, fif, fid, bub, req, tmo, busy;
    exp_t e;
    Reset_n = rst; MemRead_EX = mr; Write_Register_EX = wr; Rs_ID = rs; Rt_ID = rt;
    Branch_Taken_EX = br; Mem_Access_MEM = ma; Mem_Ready = rdy;
    {pc, ifid, idex, exmem, memwb, fif, fid, bub, req, tmo} = 10'd0;
    e.sc = m_stall;
    if (!rst) begin
      m_wait = 1'b0; m_waited = 0; m_fault = 1'b0; m_stall = 0; e.sc = 0;
    end else if (m_fault) begin
      tmo = 1'b1;
    end else begin
      busy = m_wait || ma;
      req  = busy;
      if (busy && !rdy) begin
        memwb = 1'b1; bub = 1'b1;
        if (m_wait) begin
          m_waited++;
          if (m_waited == T) begin m_fault = 1'b1; m_wait = 1'b0; end
        end else begin
          m_wait = 1'b1; m_waited = 0;
        end
      end else begin
        m_wait = 1'b0;
        {pc, ifid, idex, exmem, memwb} = 5'b11111;
        if (br) begin
          fif = 1'b1; fid = 1'b1;
        end else if (mr && wr != 5'd0 && (wr == rs || wr == rt)) begin
          pc = 1'b0; ifid = 1'b0; fid = 1'b1;
        end
      end
      if (!pc && m_stall < 65535) m_stall++;
    end
    e.o   = {pc, ifid, idex, exmem, memwb, fif, fid, bub, req, tmo};
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit mr, input logic [4:0] wr, input logic [4:0] rs,
                     input logic [4:0] rt, input bit br, input bit ma, input bit rdy,
                     input string tag);
    @(posedge Clk); #1;
    drive(1'b1, mr, wr, rs, rt, br, ma, rdy, tag);
  endtask

  task automatic rst_cyc(input string tag);
    @(posedge Clk); #1;
    drive(1'b0, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), tag);
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  always @(negedge Clk) begin
    exp_t e;
    logic [9:0] got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {PC_Enable, IF_ID_Enable, ID_EX_Enable, EX_MEM_Enable, MEM_WB_Enable,
             IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble, Mem_Req, Mem_Timeout};
      n_cmp++;
      if (got !== e.o) begin
        n_bad++;
        $display("FAIL %s: outputs got %b expected %b (pc,ifid,idex,exmem,memwb,fif,fid,bub,req,tmo) t=%0t",
                 e.tag, got, e.o, $time);
      end
`ifdef STALL_COUNTER_EN
      n_cmp++;
      if (Stall_Count !== 16'(e.sc)) begin
        n_bad++;
        $display("FAIL %s: Stall_Count got %0d expected %0d t=%0t", e.tag, Stall_Count, e.sc, $time);
      end
`endif
    end
  end

  initial begin
    int pct;
    int fault_age;
    bit ma, rdy;
    // Reset state.
    rst_cyc("reset");
    rst_cyc("reset");
    // Load-use on Rt, then resume.
    cyc(1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, "load_use_rt");
    idle("after_load_use");
    cyc(1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, "load_use_rs");
    // Register 0 never stalls; branch overrides load-use.
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, "r0_no_stall");
    cyc(1'b1, 5'd8, 5'd8, 5'd2, 1'b1, 1'b0, 1'b0, "branch_over_hazard");
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, "branch_only");
    // Zero-wait access and stray Mem_Ready with no request.
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, "zero_wait");
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, "stray_ready");
    // Three-cycle memory wait, hazards/branch ignored while frozen.
    cyc(1'b1, 5'd4, 5'd4, 5'd4, 1'b0, 1'b1, 1'b0, "wait3_c0");
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, "wait3_c1");
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, "wait3_c2");
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, "wait3_done");
    idle("wait3_run");
    // Timeout into FAULT, sticky until reset.
    for (int i = 0; i < T + 6; i++) cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, "timeout");
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, "fault_sticky");
    rst_cyc("fault_reset");
    idle("after_fault_reset");
    // Reset asserted in the middle of a wait.
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, "midwait_c0");
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, "midwait_c1");
    rst_cyc("midwait_reset");
    idle("midwait_release");
    idle("midwait_run");
    // Randomized traffic.
    pct = 50; fault_age = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        case ($urandom_range(0, 2))
          0: pct = 0;
          1: pct = 30;
          default: pct = 85;
        endcase
      end
      fault_age = m_fault ? fault_age + 1 : 0;
      if (fault_age > 4 || $urandom_range(0, 199) == 0) begin
        rst_cyc("rand_reset");
      end else begin
        ma  = ($urandom_range(0, 3) == 0);
        rdy = ($urandom_range(0, 99) < pct);
        cyc(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), ma, rdy, "random");
      end
    end
`ifdef STALL_COUNTER_EN
    rst_cyc("sat_reset");
    for (int i = 0; i < 70000; i++) cyc(1'b1, 5'd1, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, "stall_saturate");
    idle("sat_end");
`endif
    @(posedge Clk); #1;
    @(negedge Clk); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
